acc_link_unit: RTL and testbench
================================

Name: acc_link_unit

Overview:
- Parametrised accumulator plus link (carry) register for the accumulator-style datapath.
- Executes group-1 style micro-op commands (clear, complement, increment, multi-step rotate through link) as a short multi-cycle sequence with a start/busy/done handshake.
- Also supports a single-cycle direct load from the datapath.
- Provides zero and negative status flags to the controller.

Parameters:
- WIDTH, 12, accumulator width in bits (>=2).
- CNT_W, 4, width of the rotate step count field.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  direct write of acc_in/link_in; honoured only when idle
- acc_in  in  WIDTH  load data for accumulator
- link_in  in  1  load data for link
- start  in  1  begin micro-op command; honoured only when idle
- cla  in  1  command: clear accumulator
- cll  in  1  command: clear link
- cma  in  1  command: complement accumulator
- cml  in  1  command: complement link
- iac  in  1  command: increment {link,acc}
- ral  in  1  command: rotate {link,acc} left
- rar  in  1  command: rotate {link,acc} right
- rot_cnt  in  CNT_W  number of rotate steps; 0 means no rotation
- acc  out  WIDTH  accumulator value
- link  out  1  link value
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a command completes
- cmd_err  out  1  one-cycle pulse, coincident with done, when ral and rar are both set
- acc_zero  out  1  acc == 0 (combinational)
- acc_neg  out  1  acc[WIDTH-1] (combinational, two's complement sign)

Behaviour:
- Reset (asynchronous, immediate): acc=0, link=0, state=IDLE, busy=0, done=0, cmd_err=0, latched command cleared. Reset mid-command aborts it with no done pulse.
- States: IDLE, CLR, CMP, INC, ROT, DONE.
- IDLE, load=1: acc<=acc_in and link<=link_in on the next edge; remain in IDLE.
- IDLE, load=1 and start=1 together: load wins and start is dropped.
- IDLE, start=1 (load=0):
  - Latch all command fields and rot_cnt. Later input changes have no effect on the running command.
  - Go to the first enabled stage, in fixed order CLR, CMP, INC, ROT.
  - If no stage is enabled, go straight to DONE.
- Stage enable rules:
  - CLR is enabled by cla|cll.
  - CMP is enabled by cma|cml.
  - INC is enabled by iac.
  - ROT is enabled by exactly one of ral/rar together with rot_cnt != 0.
- Each stage takes exactly one cycle, except ROT, then moves to the next enabled stage or DONE:
  - CLR: acc<=0 if cla; link<=0 if cll.
  - CMP: acc<=~acc if cma; link<=~link if cml.
  - INC: {link,acc}<={link,acc}+1 modulo 2^(WIDTH+1). An all-ones {link,acc} wraps to all zeros.
- ROT:
  - Lasts rot_cnt cycles, one rotate step per cycle, using an internal down-counter loaded from rot_cnt.
  - ral step: {link,acc}<={acc,link}, i.e. link<=acc[WIDTH-1].
  - rar step: {link,acc}<={acc[0],link,acc[WIDTH-1:1]}.
- ral and rar both set: ROT is skipped, the other stages run normally, and cmd_err pulses with done.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 during DONE; done and busy fall together.
- Latency: cycles from start edge to done = (number of enabled single-cycle stages) + (rot_cnt if ROT is enabled) + 1.
- start or load while busy: ignored, with no queueing.
- Flags always reflect the current registered acc, including while busy.

Decomposition:
- Shared package acc_pkg:
  - state enum type (IDLE, CLR, CMP, INC, ROT, DONE).
  - packed cmd_t struct {cla, cll, cma, cml, iac, ral, rar, rot_cnt}.
  - helper function next_stage(state, cmd) returning the next enabled stage.
- One natural sub-module: acc_rot_step. It is combinational; given {link,acc} and a direction, it returns the rotated value, and is reused for each ROT cycle.
- The FSM, counter and registers stay in acc_link_unit.

Test Plan (WIDTH=12):
- Load then flags: load acc_in=12'h800, link_in=1 -> next cycle acc=800, link=1, acc_neg=1, acc_zero=0; rst pulse -> acc=0, link=0, acc_zero=1, acc_neg=0 immediately (asynchronous).
- Full sequence: acc=12'h00F, link=0; start with cla,cma,iac,ral,rot_cnt=1 -> CLR→CMP→INC→ROT(1)→DONE:
  - after CLR: acc=000;
  - after CMP: acc=FFF;
  - after INC: acc=000, link=1;
  - after ROT: acc=001, link=0;
  - done on the 5th cycle after start.
- Multi-step rotate right: acc=12'h001, link=0, rar, rot_cnt=3 -> acc=12'h400, link=0; busy held 4 cycles (3 ROT + DONE).
- Increment wrap: acc=FFF, link=1, iac -> acc=000, link=0, acc_zero=1; done 2 cycles after start.
- Conflicts: ral and rar together with cml, link=0 -> link=1, acc unchanged, cmd_err and done pulse together. start and load in the same idle cycle -> load applied, no busy. start while busy -> ignored, total latency unchanged.
- Reset mid-ROT (rot_cnt=8, rst asserted at step 4) -> acc=0, link=0, busy=0, no done pulse; a new command after reset runs normally.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accumulator/link unit: FSM states, latched command
// record and the stage-sequencing helper.
package acc_pkg;

    localparam int unsigned CMD_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        CMP,
        INC,
        ROT,
        DONE
    } state_t;

    typedef struct packed {
        logic                 cla;
        logic                 cll;
        logic                 cma;
        logic                 cml;
        logic                 iac;
        logic                 ral;
        logic                 rar;
        logic [CMD_CNT_W-1:0] rot_cnt;
    } cmd_t;

    // Next enabled stage after cur, walking the fixed order CLR, CMP, INC, ROT.
    function automatic state_t next_stage(input state_t cur, input cmd_t cmd);
        logic   clr_en;
        logic   cmp_en;
        logic   inc_en;
        logic   rot_en;
        state_t nxt;
        clr_en = cmd.cla | cmd.cll;
        cmp_en = cmd.cma | cmd.cml;
        inc_en = cmd.iac;
        rot_en = (cmd.ral ^ cmd.rar) && (cmd.rot_cnt != '0);
        nxt    = DONE;
        if (rot_en && (cur inside {IDLE, CLR, CMP, INC})) nxt = ROT;
        if (inc_en && (cur inside {IDLE, CLR, CMP}))      nxt = INC;
        if (cmp_en && (cur inside {IDLE, CLR}))           nxt = CMP;
        if (clr_en && (cur == IDLE))                      nxt = CLR;
        return nxt;
    endfunction

endpackage

// File: rtl/acc_link_unit_if.sv
// Controller-side bundle of the accumulator/link unit: load path, micro-op
// command with start/busy/done handshake, and status flags.
interface acc_link_unit_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] acc_in;
    logic             link_in;
    logic             start;
    logic             cla;
    logic             cll;
    logic             cma;
    logic             cml;
    logic             iac;
    logic             ral;
    logic             rar;
    logic [CNT_W-1:0] rot_cnt;
    logic [WIDTH-1:0] acc;
    logic             link;
    logic             busy;
    logic             done;
    logic             cmd_err;
    logic             acc_zero;
    logic             acc_neg;

    modport master (
        output load, acc_in, link_in, start,
        output cla, cll, cma, cml, iac, ral, rar, rot_cnt,
        input  acc, link, busy, done, cmd_err, acc_zero, acc_neg
    );

    modport slave (
        input  load, acc_in, link_in, start,
        input  cla, cll, cma, cml, iac, ral, rar, rot_cnt,
        output acc, link, busy, done, cmd_err, acc_zero, acc_neg
    );
endinterface

// File: rtl/acc_rot_step.sv
// One-bit rotate of the {link,acc} word, left or right; reused every ROT cycle.
module acc_rot_step #(
    parameter int unsigned WIDTH = 12
) (
    input  logic [WIDTH:0] val,
    input  logic           left,
    output logic [WIDTH:0] res
);
    always_comb begin
        if (left) res = {val[WIDTH-1:0], val[WIDTH]};
        else      res = {val[0], val[WIDTH:1]};
    end
endmodule

// File: rtl/acc_link_unit.sv
// Accumulator plus link register executing group-1 micro-op sequences
// (clear, complement, increment, rotate) with a start/busy/done handshake.
module acc_link_unit
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = CMD_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    acc_link_unit_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    cmd_t             cmd;
    cmd_t             cmd_nxt;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt;
    logic             link_r;
    logic             link_nxt;
    logic [CNT_W-1:0] rot_left;
    logic [CNT_W-1:0] rot_left_nxt;
    logic             busy_r;
    logic             busy_nxt;
    logic             done_r;
    logic             done_nxt;
    logic             err_r;
    logic             err_nxt;
    logic [WIDTH:0]   rot_res;

    acc_rot_step #(.WIDTH(WIDTH)) u_rot (
        .val  ({link_r, acc_r}),
        .left (cmd.ral),
        .res  (rot_res)
    );

    // State, datapath and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= '0;
            acc_r    <= '0;
            link_r   <= 1'b0;
            rot_left <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            acc_r    <= acc_nxt;
            link_r   <= link_nxt;
            rot_left <= rot_left_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
        end
    end

    // Next-state and datapath update; each stage hands off via next_stage.
    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        acc_nxt      = acc_r;
        link_nxt     = link_r;
        rot_left_nxt = rot_left;

        case (state)
            IDLE: begin
                if (bus.load) begin
                    acc_nxt  = bus.acc_in;
                    link_nxt = bus.link_in;
                end else if (bus.start) begin
                    cmd_nxt.cla     = bus.cla;
                    cmd_nxt.cll     = bus.cll;
                    cmd_nxt.cma     = bus.cma;
                    cmd_nxt.cml     = bus.cml;
                    cmd_nxt.iac     = bus.iac;
                    cmd_nxt.ral     = bus.ral;
                    cmd_nxt.rar     = bus.rar;
                    cmd_nxt.rot_cnt = CMD_CNT_W'(bus.rot_cnt);
                    rot_left_nxt    = bus.rot_cnt;
                    state_nxt       = next_stage(IDLE, cmd_nxt);
                end
            end
            CLR: begin
                if (cmd.cla) acc_nxt = '0;
                if (cmd.cll) link_nxt = 1'b0;
                state_nxt = next_stage(CLR, cmd);
            end
            CMP: begin
                if (cmd.cma) acc_nxt = ~acc_r;
                if (cmd.cml) link_nxt = ~link_r;
                state_nxt = next_stage(CMP, cmd);
            end
            INC: begin
                {link_nxt, acc_nxt} = {link_r, acc_r} + (WIDTH + 1)'(1);
                state_nxt = next_stage(INC, cmd);
            end
            ROT: begin
                {link_nxt, acc_nxt} = rot_res;
                rot_left_nxt        = rot_left - CNT_W'(1);
                if (rot_left == CNT_W'(1)) state_nxt = next_stage(ROT, cmd);
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        err_nxt  = done_nxt & cmd_nxt.ral & cmd_nxt.rar;
    end

    assign bus.acc      = acc_r;
    assign bus.link     = link_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.cmd_err  = err_r;
    assign bus.acc_zero = (acc_r == '0);
    assign bus.acc_neg  = acc_r[WIDTH-1];

endmodule

// File: tb/tb_acc_link_unit.sv
// Scoreboarded bench for acc_link_unit: directed cases then random commands,
// checked against an arithmetic model of the {link,acc} word.
module tb_acc_link_unit;

    localparam int unsigned W    = 12;
    localparam int unsigned CW   = 4;
    localparam int          AMSK = (1 << W) - 1;
    localparam int          VMSK = (1 << (W + 1)) - 1;

    typedef struct {
        int acc;
        int link;
        int err;
        int edge_no;
    } exp_t;

    typedef struct {
        bit cla, cll, cma, cml, iac, ral, rar;
        int cnt;
    } cmd_s;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    int   m_acc    = 0;
    int   m_link   = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    acc_link_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    acc_link_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: apply the command to the 13-bit word {link,acc} arithmetically.
    function automatic void run_model(input cmd_s c, inout int a, inout int l,
                                      output int err, output int lat);
        int v;
        if (c.cla) a = 0;
        if (c.cll) l = 0;
        if (c.cma) a = a ^ AMSK;
        if (c.cml) l = l ^ 1;
        v = l * (1 << W) + a;
        if (c.iac) v = (v + 1) % (1 << (W + 1));
        if (c.ral != c.rar) begin
            for (int k = 0; k < c.cnt; k++) begin
                if (c.ral) v = ((v << 1) | (v >> W)) & VMSK;
                else       v = (v >> 1) | ((v & 1) << W);
            end
        end
        a   = v & AMSK;
        l   = v >> W;
        err = (c.ral && c.rar) ? 1 : 0;
        lat = ((c.cla || c.cll) ? 1 : 0) + ((c.cma || c.cml) ? 1 : 0) + (c.iac ? 1 : 0)
            + ((c.ral != c.rar) ? c.cnt : 0) + 1;
    endfunction

    function automatic cmd_s rand_cmd();
        cmd_s c;
        c.cla = 1'($urandom % 4 == 0);
        c.cll = 1'($urandom % 4 == 0);
        c.cma = 1'($urandom % 3 == 0);
        c.cml = 1'($urandom % 3 == 0);
        c.iac = 1'($urandom % 2);
        c.ral = 1'($urandom % 3 == 0);
        c.rar = 1'($urandom % 3 == 0);
        c.cnt = int'($urandom % 16);
        return c;
    endfunction

    task automatic drive_cmd(input cmd_s c);
        bus.cla     = c.cla;
        bus.cll     = c.cll;
        bus.cma     = c.cma;
        bus.cml     = c.cml;
        bus.iac     = c.iac;
        bus.ral     = c.ral;
        bus.rar     = c.rar;
        bus.rot_cnt = CW'(c.cnt);
    endtask

    task automatic poke_inputs();
        drive_cmd(rand_cmd());
        bus.start   = 1'($urandom % 2);
        bus.load    = 1'($urandom % 2);
        bus.acc_in  = W'($urandom);
        bus.link_in = 1'($urandom % 2);
    endtask

    // Issue start at a negedge and queue the expected completion.
    task automatic issue(input cmd_s c, output int lat);
        exp_t e;
        int   err;
        drive_cmd(c);
        bus.load  = 1'b0;
        bus.start = 1'b1;
        run_model(c, m_acc, m_link, err, lat);
        e.acc     = m_acc;
        e.link    = m_link;
        e.err     = err;
        e.edge_no = edge_cnt + lat;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_cmd(input cmd_s c, input bit poke);
        int lat;
        int n      = 0;
        int busy_n = 0;
        issue(c, lat);
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            if (poke) poke_inputs();
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
        if (bus.busy === 1'b1) busy_n++;
        check("busy_cycles", busy_n, lat);
        if (poke) poke_inputs();
        @(negedge clk);
        bus.start = 1'b0;
        bus.load  = 1'b0;
        check("idle_after_done", bus.busy, 32'd0);
    endtask

    task automatic do_load(input int a, input int l, input bit with_start);
        bus.load    = 1'b1;
        bus.acc_in  = W'(a);
        bus.link_in = 1'(l);
        bus.start   = with_start;
        if (with_start) drive_cmd(rand_cmd());
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        m_acc     = a;
        m_link    = l;
        check("load_acc", bus.acc, a);
        check("load_link", bus.link, l);
        check("load_busy", bus.busy, 32'd0);
        check("load_zero", bus.acc_zero, (a == 0) ? 1 : 0);
        check("load_neg", bus.acc_neg, (a >> (W - 1)) & 1);
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_acc", bus.acc, e.acc);
                    check("done_link", bus.link, e.link);
                    check("done_cmd_err", bus.cmd_err, e.err);
                    check("done_latency", edge_cnt, e.edge_no);
                    check("done_zero", bus.acc_zero, (e.acc == 0) ? 1 : 0);
                    check("done_neg", bus.acc_neg, (e.acc >> (W - 1)) & 1);
                    check("done_busy", bus.busy, 32'd1);
                end
            end else if (bus.cmd_err !== 1'b0) begin
                check("stray_cmd_err", bus.cmd_err, 32'd0);
            end
        end
    end

    initial begin
        cmd_s c;
        int   lat;
        rst         = 1'b1;
        bus.load    = 1'b0;
        bus.start   = 1'b0;
        bus.acc_in  = '0;
        bus.link_in = 1'b0;
        drive_cmd('{default: 0});
        repeat (2) @(negedge clk);
        check("rst_acc", bus.acc, 32'd0);
        check("rst_link", bus.link, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_done", bus.done, 32'd0);
        check("rst_zero", bus.acc_zero, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Load then asynchronous reset.
        do_load('h800, 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_acc", bus.acc, 32'd0);
        check("arst_link", bus.link, 32'd0);
        check("arst_zero", bus.acc_zero, 32'd1);
        check("arst_neg", bus.acc_neg, 32'd0);
        m_acc  = 0;
        m_link = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full CLR -> CMP -> INC -> ROT(1) sequence with per-stage values.
        do_load('h00F, 0, 1'b0);
        c = '{cla: 1, cll: 0, cma: 1, cml: 0, iac: 1, ral: 1, rar: 0, cnt: 1};
        issue(c, lat);
        check("seq_busy", bus.busy, 32'd1);
        check("seq_lat", lat, 32'd5);
        @(negedge clk);
        check("seq_clr_acc", bus.acc, 32'h000);
        @(negedge clk);
        check("seq_cmp_acc", bus.acc, 32'hFFF);
        @(negedge clk);
        check("seq_inc_acc", bus.acc, 32'h000);
        check("seq_inc_link", bus.link, 32'd1);
        @(negedge clk);
        check("seq_rot_acc", bus.acc, 32'h001);
        check("seq_rot_link", bus.link, 32'd0);
        check("seq_done", bus.done, 32'd1);
        @(negedge clk);

        // Multi-step rotate right.
        do_load('h001, 0, 1'b0);
        run_cmd('{cla: 0, cll: 0, cma: 0, cml: 0, iac: 0, ral: 0, rar: 1, cnt: 3}, 1'b0);
        check("rar3_acc", bus.acc, 32'h400);

        // Increment wrap of all-ones {link,acc}.
        do_load('hFFF, 1, 1'b0);
        run_cmd('{cla: 0, cll: 0, cma: 0, cml: 0, iac: 1, ral: 0, rar: 0, cnt: 0}, 1'b0);
        check("wrap_zero", bus.acc_zero, 32'd1);

        // ral+rar conflict: rotate skipped, cmd_err with done.
        do_load('h5A3, 0, 1'b0);
        run_cmd('{cla: 0, cll: 0, cma: 0, cml: 1, iac: 0, ral: 1, rar: 1, cnt: 5}, 1'b0);
        check("conf_acc", bus.acc, 32'h5A3);
        check("conf_link", bus.link, 32'd1);

        // start together with load: load wins.
        do_load('h123, 1, 1'b1);
        @(negedge clk);
        check("ldst_busy", bus.busy, 32'd0);

        // start/load noise while busy must not disturb the command.
        run_cmd('{cla: 0, cll: 0, cma: 1, cml: 0, iac: 1, ral: 1, rar: 0, cnt: 6}, 1'b1);

        // Reset in the middle of an 8-step rotate.
        do_load('hABC, 1, 1'b0);
        issue('{cla: 0, cll: 0, cma: 0, cml: 0, iac: 0, ral: 1, rar: 0, cnt: 8}, lat);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_acc  = 0;
        m_link = 0;
        check("mid_acc", bus.acc, 32'd0);
        check("mid_link", bus.link, 32'd0);
        check("mid_busy", bus.busy, 32'd0);
        check("mid_done", bus.done, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_cmd('{cla: 0, cll: 0, cma: 1, cml: 1, iac: 0, ral: 0, rar: 1, cnt: 2}, 1'b0);

        // Random mix of loads and commands.
        for (int i = 0; i < 80; i++) begin
            if ($urandom % 4 == 0) do_load(int'($urandom) & AMSK, int'($urandom % 2), 1'($urandom % 2));
            else                   run_cmd(rand_cmd(), 1'($urandom % 2));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
